lsu_trace_monitor: RTL and testbench
====================================

LSU_TRACE_MONITOR -- requirements
Module: lsu_trace_monitor

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2: entries per read/write event queue, power of two, at least 2.
REQ-002 SHALL have port clock, input, 1: sole clock, rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have inputs ar_valid, ar_ready (1 each), ar_addr (32) and ar_size (3): observed LSU read-address channel.
REQ-005 SHALL have inputs r_valid, r_ready (1 each) and r_data (32): observed read-data channel.
REQ-006 SHALL have inputs aw_valid, aw_ready (1 each), aw_addr (32) and aw_size (3): observed write-address channel.
REQ-007 SHALL have inputs w_valid, w_ready (1 each), w_data (32) and w_strb (4): observed write-data channel.
REQ-008 SHALL have inputs b_valid and b_ready (1 each): observed write-response channel.
REQ-009 SHALL have outputs raddr, rlen and rdata (32 each) and ren (1): read trace event to the downstream tracer.
REQ-010 SHALL have outputs waddr, wlen and wdata (32 each) and wen (1): write trace event to the downstream tracer.
REQ-011 SHALL have outputs proto_err and overflow (1 each): sticky error flags.

Function
REQ-012 SHALL be a passive monitor: every input is observe-only, and no output feeds back to the bus.
REQ-013 SHALL define a handshake as valid&ready sampled high at a rising clock edge.
REQ-014 SHALL compute len as 1<<size for size 0..2, and len=4 with proto_err set for size>2.
REQ-015 SHALL run a read FSM with states R_IDLE and R_WAIT.
- R_IDLE + AR handshake: capture addr/len, go to R_WAIT.
REQ-016 SHALL, in R_WAIT + R handshake, push {addr,len,r_data} into the read queue and return to R_IDLE.
- If an AR handshake occurs in the same cycle, capture the new address and stay in R_WAIT.
REQ-017 SHALL set proto_err and ignore:
- an AR handshake in R_WAIT without an R handshake;
- an R handshake in R_IDLE.
REQ-018 SHALL run a write FSM with states W_IDLE, W_HAVE_AW, W_HAVE_W and W_WAIT_B.
- AW and W handshakes arrive in either order or in the same cycle.
- W_WAIT_B is reached once both have been captured.
REQ-019 SHALL capture wdata as w_data with every byte whose w_strb bit is 0 forced to 0x00.
REQ-020 SHALL, in W_WAIT_B + B handshake, push {addr,len,wdata} into the write queue and return to W_IDLE.
- An AW/W handshake in that same cycle is captured as the start of the next transaction.
REQ-021 SHALL set proto_err and ignore:
- a duplicate AW or W handshake for a transaction already holding one;
- a B handshake outside W_WAIT_B.
REQ-022 SHALL, on a push into a full queue, drop the new event and set overflow.
- Exception: a pop in the same cycle frees one slot, so the push succeeds with no drop.
REQ-023 SHALL pop the read queue in any cycle where it is non-empty and ren is 0.
- At that edge, load raddr/rlen/rdata and drive ren=1 for exactly one cycle.
- The write side (wen, waddr/wlen/wdata) behaves identically.
REQ-024 SHALL keep ren/wen low for at least one cycle between pulses, giving a maximum rate of one event per two cycles per side, so each event is a distinct rising edge.
REQ-025 SHALL hold the event data outputs stable from one pop until the next pop.
REQ-026 SHALL produce latency: completing handshake at edge N -> ren/wen high in the cycle after edge N+1, when the queue was empty and the pulse was low.
REQ-027 SHALL operate the read and write paths fully independently, including simultaneous completions.
REQ-028 SHALL preserve completion order within each queue, with pointers wrapping modulo FIFO_DEPTH.

Reset
REQ-029 SHALL, while reset=0, asynchronously force:
- both FSMs to IDLE and both queues empty;
- all outputs, including proto_err and overflow, to 0.
REQ-030 SHALL, on reset assertion mid-transaction, discard partial captures and queued events, and drop ren/wen immediately.
REQ-031 SHALL clear proto_err and overflow only by reset.

Verification
REQ-032 SHALL cover: AR 0x8000_0010 size 2, R data 0xDEADBEEF one cycle later -> single ren pulse with raddr=0x80000010, rlen=4, rdata=0xDEADBEEF.
REQ-033 SHALL cover: W before AW (addr 0x8000_0020, size 0, w_data 0x11223344, strb 0001), then B -> single wen pulse with wlen=1, wdata=0x00000044.
REQ-034 SHALL cover: three reads completing on consecutive cycles, FIFO_DEPTH=2 -> pulses every second cycle with data in order; no event lost because each pop frees a slot; overflow=0.
REQ-035 SHALL cover: five back-to-back write completions with FIFO_DEPTH=2 -> overflow=1, and the emitted events are the in-order subset accepted.
REQ-036 SHALL cover: R handshake in R_IDLE, and ar_size=3 -> proto_err=1 and no ren pulse from the stray R.
REQ-037 SHALL cover: reset asserted one cycle after an AR handshake with the event still pending -> no ren after release; outputs and flags 0.

Source files
------------

// File: rtl/lsu_trace_monitor_if.sv
// Observed LSU bus: read/write address, data and response channels.
// The LSU side drives every signal; the trace monitor only listens.
interface lsu_trace_monitor_if;
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] ar_addr;
  logic [2:0]  ar_size;
  logic        r_valid;
  logic        r_ready;
  logic [31:0] r_data;
  logic        aw_valid;
  logic        aw_ready;
  logic [31:0] aw_addr;
  logic [2:0]  aw_size;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        b_valid;
  logic        b_ready;

  modport master (
    output ar_valid, ar_ready, ar_addr, ar_size,
    output r_valid, r_ready, r_data,
    output aw_valid, aw_ready, aw_addr, aw_size,
    output w_valid, w_ready, w_data, w_strb,
    output b_valid, b_ready
  );

  modport slave (
    input ar_valid, ar_ready, ar_addr, ar_size,
    input r_valid, r_ready, r_data,
    input aw_valid, aw_ready, aw_addr, aw_size,
    input w_valid, w_ready, w_data, w_strb,
    input b_valid, b_ready
  );
endinterface

// File: rtl/lsu_trace_monitor.sv
// Passive LSU bus trace monitor. Completed reads and writes are assembled
// into {addr, len, data} events, queued, and replayed to the downstream
// tracer as single-cycle pulses separated by at least one idle cycle.

// Event queue with a registered one-cycle output pulse.
module lsu_trace_monitor_queue #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_push,
  input  logic [95:0] i_pushData,
  output logic [95:0] o_data,
  output logic        o_pulse,
  output logic        o_drop
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  logic [95:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;
  logic             w_full;
  logic             w_accept;

  // A pop only happens while the pulse is low, which forces the idle gap.
  // A pop in the same cycle frees the slot a push into a full queue needs.
  assign w_pop    = (r_count != '0) && !o_pulse;
  assign w_full   = (r_count == FULL_COUNT);
  assign w_accept = i_push && (!w_full || w_pop);
  assign o_drop   = i_push && w_full && !w_pop;

  // Storage array needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (w_accept) r_mem[r_wrPtr] <= i_pushData;
  end

  // Pointers, occupancy and the registered output event.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      o_pulse <= 1'b0;
      o_data  <= '0;
    end else begin
      o_pulse <= w_pop;
      if (w_accept) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
        o_data  <= r_mem[r_rdPtr];
      end
      if (w_accept && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_accept && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end
endmodule

module lsu_trace_monitor #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clock,
  input  logic                reset,
  lsu_trace_monitor_if.slave  bus,
  output logic [31:0]         raddr,
  output logic [31:0]         rlen,
  output logic [31:0]         rdata,
  output logic                ren,
  output logic [31:0]         waddr,
  output logic [31:0]         wlen,
  output logic [31:0]         wdata,
  output logic                wen,
  output logic                proto_err,
  output logic                overflow
);
  typedef enum logic {R_IDLE, R_WAIT} readState_t;
  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_WAIT_B} writeState_t;

  readState_t  r_readState, w_readNext;
  writeState_t r_writeState, w_writeNext;

  logic        w_arHs, w_rHs, w_awHs, w_wHs, w_bHs;
  logic        w_readCapture, w_readPush, w_readErr;
  logic        w_awCapture, w_wCapture, w_writePush, w_writeErr;
  logic [31:0] r_readAddr, r_readLen;
  logic [31:0] r_writeAddr, r_writeLen, r_writeData;
  logic [31:0] w_wMasked;
  logic        w_readDrop, w_writeDrop;

  function automatic logic [31:0] sizeToLen(input logic [2:0] size);
    return (size > 3'd2) ? 32'd4 : (32'd1 << size);
  endfunction

  assign w_arHs = bus.ar_valid && bus.ar_ready;
  assign w_rHs  = bus.r_valid  && bus.r_ready;
  assign w_awHs = bus.aw_valid && bus.aw_ready;
  assign w_wHs  = bus.w_valid  && bus.w_ready;
  assign w_bHs  = bus.b_valid  && bus.b_ready;

  assign w_wMasked = bus.w_data & {{8{bus.w_strb[3]}}, {8{bus.w_strb[2]}},
                                   {8{bus.w_strb[1]}}, {8{bus.w_strb[0]}}};

  // Read FSM: an AR opens a transaction, the matching R closes it.
  always_comb begin
    w_readNext    = r_readState;
    w_readCapture = 1'b0;
    w_readPush    = 1'b0;
    w_readErr     = 1'b0;
    case (r_readState)
      R_IDLE: begin
        if (w_rHs) w_readErr = 1'b1;
        if (w_arHs) begin
          w_readCapture = 1'b1;
          w_readNext    = R_WAIT;
        end
      end
      R_WAIT: begin
        if (w_rHs) begin
          w_readPush = 1'b1;
          if (w_arHs) w_readCapture = 1'b1;
          else        w_readNext    = R_IDLE;
        end else if (w_arHs) begin
          w_readErr = 1'b1;
        end
      end
      default: w_readNext = R_IDLE;
    endcase
    if (w_readCapture && bus.ar_size > 3'd2) w_readErr = 1'b1;
  end

  // Write FSM: AW and W may arrive in either order; B closes the transaction.
  always_comb begin
    w_writeNext = r_writeState;
    w_awCapture = 1'b0;
    w_wCapture  = 1'b0;
    w_writePush = 1'b0;
    w_writeErr  = 1'b0;
    case (r_writeState)
      W_IDLE: begin
        if (w_bHs) w_writeErr = 1'b1;
        w_awCapture = w_awHs;
        w_wCapture  = w_wHs;
      end
      W_HAVE_AW: begin
        if (w_bHs || w_awHs) w_writeErr = 1'b1;
        w_wCapture = w_wHs;
        if (w_wHs) w_writeNext = W_WAIT_B;
      end
      W_HAVE_W: begin
        if (w_bHs || w_wHs) w_writeErr = 1'b1;
        w_awCapture = w_awHs;
        if (w_awHs) w_writeNext = W_WAIT_B;
      end
      W_WAIT_B: begin
        if (w_bHs) begin
          w_writePush = 1'b1;
          w_awCapture = w_awHs;
          w_wCapture  = w_wHs;
          w_writeNext = W_IDLE;
        end else if (w_awHs || w_wHs) begin
          w_writeErr = 1'b1;
        end
      end
      default: w_writeNext = W_IDLE;
    endcase
    if ((r_writeState == W_IDLE) || w_writePush) begin
      if (w_awHs && w_wHs) w_writeNext = W_WAIT_B;
      else if (w_awHs)     w_writeNext = W_HAVE_AW;
      else if (w_wHs)      w_writeNext = W_HAVE_W;
    end
    if (w_awCapture && bus.aw_size > 3'd2) w_writeErr = 1'b1;
  end

  // State registers, captured transaction fields and sticky error flags.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_readState  <= R_IDLE;
      r_writeState <= W_IDLE;
      r_readAddr   <= '0;
      r_readLen    <= '0;
      r_writeAddr  <= '0;
      r_writeLen   <= '0;
      r_writeData  <= '0;
      proto_err    <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      r_readState  <= w_readNext;
      r_writeState <= w_writeNext;
      if (w_readCapture) begin
        r_readAddr <= bus.ar_addr;
        r_readLen  <= sizeToLen(bus.ar_size);
      end
      if (w_awCapture) begin
        r_writeAddr <= bus.aw_addr;
        r_writeLen  <= sizeToLen(bus.aw_size);
      end
      if (w_wCapture) r_writeData <= w_wMasked;
      if (w_readErr || w_writeErr)   proto_err <= 1'b1;
      if (w_readDrop || w_writeDrop) overflow  <= 1'b1;
    end
  end

  lsu_trace_monitor_queue #(.FIFO_DEPTH(FIFO_DEPTH)) readQueue (
    .clock      (clock),
    .reset      (reset),
    .i_push     (w_readPush),
    .i_pushData ({r_readAddr, r_readLen, bus.r_data}),
    .o_data     ({raddr, rlen, rdata}),
    .o_pulse    (ren),
    .o_drop     (w_readDrop)
  );

  lsu_trace_monitor_queue #(.FIFO_DEPTH(FIFO_DEPTH)) writeQueue (
    .clock      (clock),
    .reset      (reset),
    .i_push     (w_writePush),
    .i_pushData ({r_writeAddr, r_writeLen, r_writeData}),
    .o_data     ({waddr, wlen, wdata}),
    .o_pulse    (wen),
    .o_drop     (w_writeDrop)
  );
endmodule

// File: tb/tb_lsu_trace_monitor.sv
// Directed bench for lsu_trace_monitor: hand-computed trace events,
// pulse spacing, overflow, protocol errors and reset behaviour.
module tb_lsu_trace_monitor;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] raddr, rlen, rdata, waddr, wlen, wdata;
  logic        ren, wen, proto_err, overflow;
  int          compareCount = 0;
  int          failCount = 0;
  int          renPulses = 0;
  int          wenPulses = 0;
  int          base;

  lsu_trace_monitor_if bus ();

  lsu_trace_monitor #(.FIFO_DEPTH(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .raddr     (raddr),
    .rlen      (rlen),
    .rdata     (rdata),
    .ren       (ren),
    .waddr     (waddr),
    .wlen      (wlen),
    .wdata     (wdata),
    .wen       (wen),
    .proto_err (proto_err),
    .overflow  (overflow)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clock = ~clock;

  // Count trace pulses mid-cycle so every one-cycle pulse is seen once.
  always @(negedge clock) begin
    if (ren) renPulses++;
    if (wen) wenPulses++;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    assert (observed === expected)
      else begin
        failCount++;
        $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
  endtask

  task automatic clearBus();
    bus.ar_valid = 0; bus.ar_ready = 0; bus.ar_addr = '0; bus.ar_size = '0;
    bus.r_valid  = 0; bus.r_ready  = 0; bus.r_data  = '0;
    bus.aw_valid = 0; bus.aw_ready = 0; bus.aw_addr = '0; bus.aw_size = '0;
    bus.w_valid  = 0; bus.w_ready  = 0; bus.w_data  = '0; bus.w_strb  = '0;
    bus.b_valid  = 0; bus.b_ready  = 0;
  endtask

  // Drive one cycle of handshakes, pass one rising edge, then go idle.
  task automatic applyStimulus(
      input logic arHs, input logic [31:0] arAddr, input logic [2:0] arSize,
      input logic rHs,  input logic [31:0] rData,
      input logic awHs, input logic [31:0] awAddr, input logic [2:0] awSize,
      input logic wHs,  input logic [31:0] wData,  input logic [3:0] wStrb,
      input logic bHs);
    bus.ar_valid = arHs; bus.ar_ready = arHs; bus.ar_addr = arAddr; bus.ar_size = arSize;
    bus.r_valid  = rHs;  bus.r_ready  = rHs;  bus.r_data  = rData;
    bus.aw_valid = awHs; bus.aw_ready = awHs; bus.aw_addr = awAddr; bus.aw_size = awSize;
    bus.w_valid  = wHs;  bus.w_ready  = wHs;  bus.w_data  = wData;  bus.w_strb  = wStrb;
    bus.b_valid  = bHs;  bus.b_ready  = bHs;
    @(posedge clock);
    #1;
    clearBus();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b0;
    clearBus();
    #12;
    checkOutput("reset_ren", 32'(ren), 32'd0);
    checkOutput("reset_wen", 32'(wen), 32'd0);
    checkOutput("reset_proto_err", 32'(proto_err), 32'd0);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);
    checkOutput("reset_raddr", raddr, 32'd0);
    checkOutput("reset_wdata", wdata, 32'd0);
    reset = 1'b1;

    // Valid without ready is not a handshake.
    bus.ar_valid = 1; bus.r_valid = 1; bus.aw_valid = 1; bus.w_valid = 1; bus.b_valid = 1;
    @(posedge clock); #1;
    clearBus();
    idle(3);
    checkOutput("noready_proto_err", 32'(proto_err), 32'd0);
    checkOutput("noready_ren", 32'(renPulses), 32'd0);
    checkOutput("noready_wen", 32'(wenPulses), 32'd0);

    // Single read: AR then R one cycle later.
    base = renPulses;
    applyStimulus(1, 32'h8000_0010, 3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rd1_latency_ren", 32'(ren), 32'd0);
    idle(1);
    checkOutput("rd1_ren", 32'(ren), 32'd1);
    checkOutput("rd1_raddr", raddr, 32'h8000_0010);
    checkOutput("rd1_rlen", rlen, 32'd4);
    checkOutput("rd1_rdata", rdata, 32'hDEAD_BEEF);
    idle(1);
    checkOutput("rd1_ren_low", 32'(ren), 32'd0);
    checkOutput("rd1_raddr_hold", raddr, 32'h8000_0010);
    idle(3);
    checkOutput("rd1_pulse_count", 32'(renPulses - base), 32'd1);

    // Single write: W before AW, byte strobe 0001, then B.
    base = wenPulses;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1122_3344, 4'b0001, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h8000_0020, 3'd0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("wr1_latency_wen", 32'(wen), 32'd0);
    idle(1);
    checkOutput("wr1_wen", 32'(wen), 32'd1);
    checkOutput("wr1_waddr", waddr, 32'h8000_0020);
    checkOutput("wr1_wlen", wlen, 32'd1);
    checkOutput("wr1_wdata", wdata, 32'h0000_0044);
    idle(3);
    checkOutput("wr1_pulse_count", 32'(wenPulses - base), 32'd1);

    // Three reads completing on consecutive edges.
    base = renPulses;
    applyStimulus(1, 32'h0000_1000, 3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h0000_2000, 3'd0, 1, 32'hA0A0_A0A0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h0000_3000, 3'd2, 1, 32'hB1B1_B1B1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rd3_e0_ren", 32'(ren), 32'd1);
    checkOutput("rd3_e0_raddr", raddr, 32'h0000_1000);
    checkOutput("rd3_e0_rlen", rlen, 32'd2);
    checkOutput("rd3_e0_rdata", rdata, 32'hA0A0_A0A0);
    applyStimulus(0, 0, 0, 1, 32'hC2C2_C2C2, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rd3_gap_ren", 32'(ren), 32'd0);
    idle(1);
    checkOutput("rd3_e1_raddr", raddr, 32'h0000_2000);
    checkOutput("rd3_e1_rlen", rlen, 32'd1);
    checkOutput("rd3_e1_rdata", rdata, 32'hB1B1_B1B1);
    idle(2);
    checkOutput("rd3_e2_ren", 32'(ren), 32'd1);
    checkOutput("rd3_e2_raddr", raddr, 32'h0000_3000);
    checkOutput("rd3_e2_rlen", rlen, 32'd4);
    checkOutput("rd3_e2_rdata", rdata, 32'hC2C2_C2C2);
    idle(3);
    checkOutput("rd3_pulse_count", 32'(renPulses - base), 32'd3);
    checkOutput("rd3_overflow", 32'(overflow), 32'd0);

    // Five back-to-back write completions: the fifth is dropped.
    base = wenPulses;
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h4000_0000, 3'd2, 1, 32'hC0DE_0000, 4'hF, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h4000_0010, 3'd2, 1, 32'hC0DE_0001, 4'hF, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h4000_0020, 3'd2, 1, 32'hC0DE_0002, 4'hF, 1);
    checkOutput("wr5_e0_wen", 32'(wen), 32'd1);
    checkOutput("wr5_e0_waddr", waddr, 32'h4000_0000);
    checkOutput("wr5_e0_wlen", wlen, 32'd4);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h4000_0030, 3'd2, 1, 32'hC0DE_0003, 4'hF, 1);
    checkOutput("wr5_gap_wen", 32'(wen), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 1, 32'h4000_0040, 3'd2, 1, 32'hC0DE_0004, 4'hF, 1);
    checkOutput("wr5_e1_waddr", waddr, 32'h4000_0010);
    checkOutput("wr5_e1_wdata", wdata, 32'hC0DE_0001);
    checkOutput("wr5_no_overflow_yet", 32'(overflow), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("wr5_overflow", 32'(overflow), 32'd1);
    idle(1);
    checkOutput("wr5_e2_waddr", waddr, 32'h4000_0020);
    checkOutput("wr5_e2_wdata", wdata, 32'hC0DE_0002);
    idle(2);
    checkOutput("wr5_e3_waddr", waddr, 32'h4000_0030);
    checkOutput("wr5_e3_wdata", wdata, 32'hC0DE_0003);
    idle(4);
    checkOutput("wr5_pulse_count", 32'(wenPulses - base), 32'd4);
    checkOutput("wr5_proto_err", 32'(proto_err), 32'd0);

    // Stray R while the read side is idle.
    base = renPulses;
    applyStimulus(0, 0, 0, 1, 32'h5555_5555, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("strayR_proto_err", 32'(proto_err), 32'd1);
    idle(3);
    checkOutput("strayR_pulse_count", 32'(renPulses - base), 32'd0);

    // Flags clear only through reset.
    reset = 1'b0;
    #1;
    checkOutput("rst2_proto_err", 32'(proto_err), 32'd0);
    checkOutput("rst2_overflow", 32'(overflow), 32'd0);
    checkOutput("rst2_waddr", waddr, 32'd0);
    reset = 1'b1;

    // Oversized AR: len saturates at 4 and proto_err is raised.
    applyStimulus(1, 32'h0000_5000, 3'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("size3_proto_err", 32'(proto_err), 32'd1);
    applyStimulus(0, 0, 0, 1, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    checkOutput("size3_ren", 32'(ren), 32'd1);
    checkOutput("size3_raddr", raddr, 32'h0000_5000);
    checkOutput("size3_rlen", rlen, 32'd4);
    idle(2);

    // Reset mid-traffic with an event queued, a pulse active and an AW held.
    reset = 1'b0;
    #1;
    reset = 1'b1;
    applyStimulus(1, 32'h0000_6000, 3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h0000_7000, 3'd1, 1, 32'h0000_0066, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'h0000_0077, 1, 32'h0000_9000, 3'd2, 0, 0, 0, 0);
    checkOutput("rst3_pre_ren", 32'(ren), 32'd1);
    checkOutput("rst3_pre_raddr", raddr, 32'h0000_6000);
    reset = 1'b0;
    #1;
    checkOutput("rst3_ren_drop", 32'(ren), 32'd0);
    checkOutput("rst3_raddr", raddr, 32'd0);
    checkOutput("rst3_rdata", rdata, 32'd0);
    reset = 1'b1;
    base = renPulses;
    idle(4);
    checkOutput("rst3_no_ren", 32'(renPulses - base), 32'd0);
    checkOutput("rst3_proto_err", 32'(proto_err), 32'd0);
    base = wenPulses;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 4'hF, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("rst3_aw_discarded", 32'(proto_err), 32'd1);
    idle(3);
    checkOutput("rst3_no_wen", 32'(wenPulses - base), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end
endmodule
